// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D main-memory arbiter:
// FSM state encoding, requester IDs and default widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select between the I-cache and D-cache
// requests; round-robin on a tie, or fixed D priority.
module arb_rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic i_req,
    input  logic d_req,
    input  logic last,
    output logic valid,
    output logic pick_d
);

    // On a tie, grant whoever was not served last (or D when fixed)
    always_comb begin
        valid  = i_req | d_req;
        pick_d = d_req;
        if (i_req && d_req) begin
            if (RR_EN != 0) begin
                pick_d = (last == REQ_I);
            end else begin
                pick_d = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory block port between I-cache refill and
// D-cache refill/write-back, one transfer at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RR_EN  = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_req, d_req;
    logic              pick_valid, pick_d;
    logic              done;
    logic              in_release;

    assign i_req = I_READ;
    assign d_req = D_READ | D_WRITE;

    arb_rr_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .last   (last_q),
        .valid  (pick_valid),
        .pick_d (pick_d)
    );

    // Memory still reports idle on the first grant cycle, so
    // completion only counts from the second cycle on.
    assign done = !first_q && !MEM_BUSYWAIT;

    // Next-state, operand latching and readdata capture
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        first_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    first_d = 1'b1;
                    if (pick_d) begin
                        state_d = ST_GRANT_D;
                        addr_d  = D_ADDRESS;
                        wdata_d = D_WRITEDATA;
                        wr_d    = D_WRITE;
                    end else begin
                        state_d = ST_GRANT_I;
                        addr_d  = I_ADDRESS;
                        wr_d    = 1'b0;
                    end
                end
            end
            ST_GRANT_I: begin
                if (done) begin
                    if (i_req) begin
                        i_rdata_d = MEM_READDATA;
                    end
                    last_d  = REQ_I;
                    state_d = ST_RELEASE;
                end
            end
            ST_GRANT_D: begin
                if (done) begin
                    if (d_req && !wr_q) begin
                        d_rdata_d = MEM_READDATA;
                    end
                    last_d  = REQ_D;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            last_q    <= REQ_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            first_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            first_q   <= first_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign in_release = (state_q == ST_RELEASE);

    assign MEM_READ = (state_q == ST_GRANT_I)
                   || (state_q == ST_GRANT_D && !wr_q);
    assign MEM_WRITE = (state_q == ST_GRANT_D) && wr_q;
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;

    assign I_READDATA = i_rdata_q;
    assign D_READDATA = d_rdata_q;

    // Only the requester just served sees busywait drop
    assign I_BUSYWAIT = i_req
                     && !(in_release && last_q == REQ_I);
    assign D_BUSYWAIT = d_req
                     && !(in_release && last_q == REQ_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter against a behavioural block
// memory with settable latency; two instances (RR on / off).
module tb_mem_arbiter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         I_READ, D_READ, D_WRITE;
    logic [27:0]  I_ADDRESS, D_ADDRESS;
    logic [127:0] D_WRITEDATA;

    logic [127:0] i_rdata [2];
    logic [127:0] d_rdata [2];
    logic [1:0]   i_bw, d_bw, m_rd, m_wr, m_busy;
    logic [27:0]  m_addr [2];
    logic [127:0] m_wdata [2];
    logic [127:0] m_rdata [2];
    logic [27:0]  wr_addr [2];
    logic [127:0] wr_data [2];
    int           m_cnt [2];
    int           mem_lat;
    int           n_cmp = 0;
    int           n_err = 0;

    typedef struct {
        logic         i_rd;
        logic         d_rd;
        logic         d_wr;
        logic [27:0]  ia;
        logic [27:0]  da;
        logic [127:0] wd;
        int           lat;
        logic         d_first;
        int           t1;
        int           t2;
        int           strb;
    } vec_t;

    always #5 CLK = ~CLK;

    function automatic logic [127:0] blk(input logic [27:0] a);
        logic [31:0] w;
        w = {a, 4'h0};
        return {w + 32'd12, w + 32'd8, w + 32'd4, w};
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act,
                         input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    mem_arbiter #(.RR_EN(1)) u0 (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS),
        .I_READDATA(i_rdata[0]), .I_BUSYWAIT(i_bw[0]),
        .D_READ(D_READ), .D_WRITE(D_WRITE),
        .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(d_rdata[0]), .D_BUSYWAIT(d_bw[0]),
        .MEM_READ(m_rd[0]), .MEM_WRITE(m_wr[0]),
        .MEM_ADDRESS(m_addr[0]), .MEM_WRITEDATA(m_wdata[0]),
        .MEM_READDATA(m_rdata[0]), .MEM_BUSYWAIT(m_busy[0])
    );

    mem_arbiter #(.RR_EN(0)) u1 (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS),
        .I_READDATA(i_rdata[1]), .I_BUSYWAIT(i_bw[1]),
        .D_READ(D_READ), .D_WRITE(D_WRITE),
        .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(d_rdata[1]), .D_BUSYWAIT(d_bw[1]),
        .MEM_READ(m_rd[1]), .MEM_WRITE(m_wr[1]),
        .MEM_ADDRESS(m_addr[1]), .MEM_WRITEDATA(m_wdata[1]),
        .MEM_READDATA(m_rdata[1]), .MEM_BUSYWAIT(m_busy[1])
    );

    // Memory: busy while strobed until mem_lat edges have passed
    always_comb begin
        m_busy = '0;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = (m_rd[i] | m_wr[i])
                     && (m_cnt[i] < mem_lat);
            m_rdata[i] = blk(m_addr[i]);
        end
    end

    // Memory: transfer counter and write capture
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if ((m_rd[i] | m_wr[i]) && m_cnt[i] < mem_lat)
                m_cnt[i] <= m_cnt[i] + 1;
            else
                m_cnt[i] <= 0;
            if (m_wr[i]) begin
                wr_addr[i] <= m_addr[i];
                wr_data[i] <= m_wdata[i];
            end
        end
    end

    initial begin
        vec_t  vt [7];
        vec_t  c;
        int    t_i, t_d, strb, rises, last_hi, t6;
        int    n0, n1;
        int    gs0 [8];
        int    gs1 [8];
        logic  prev, ovl, i_pend, d_pend, s, p0, p1;

        vt[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 28'h0,
                  128'h0, 5, 1'b0, 7, 0, 6};
        vt[1] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h0000200,
                  128'h0, 3, 1'b1, 5, 0, 4};
        vt[2] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h0000300,
                  {4{32'h1111_2222}}, 2, 1'b1, 4, 0, 3};
        vt[3] = '{1'b1, 1'b1, 1'b0, 28'h0000020, 28'h0000400,
                  128'h0, 4, 1'b0, 6, 13, 10};
        vt[4] = '{1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 28'h0,
                  128'h0, 1, 1'b0, 3, 0, 2};
        vt[5] = '{1'b1, 1'b0, 1'b1, 28'h0000030, 28'h0000500,
                  {16{8'hA5}}, 3, 1'b1, 5, 11, 8};
        vt[6] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h0ABCDEF,
                  128'h0, 2, 1'b1, 4, 0, 3};

        // Reset held two cycles with an I request pending
        RESET = 1'b0;
        I_READ = 1'b1; D_READ = 1'b0; D_WRITE = 1'b0;
        I_ADDRESS = 28'h0000010; D_ADDRESS = '0;
        D_WRITEDATA = '0; mem_lat = 1;
        repeat (2) @(negedge CLK);
        chk("rst_mrd", 128'(m_rd[0]), 128'(1'b0));
        chk("rst_mwr", 128'(m_wr[0]), 128'(1'b0));
        chk("rst_addr", 128'(m_addr[0]), 128'h0);
        chk("rst_wdata", m_wdata[0], 128'h0);
        chk("rst_irdata", i_rdata[0], 128'h0);
        chk("rst_drdata", d_rdata[0], 128'h0);
        chk("rst_ibw", 128'(i_bw[0]), 128'(1'b1));
        I_READ = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_nogrant", 128'(m_rd[0]), 128'(1'b0));

        // Table of single and contended transfers
        for (int v = 0; v < 7; v++) begin
            c = vt[v];
            mem_lat = c.lat;
            @(negedge CLK);
            I_ADDRESS = c.ia; D_ADDRESS = c.da;
            D_WRITEDATA = c.wd;
            I_READ = c.i_rd; D_READ = c.d_rd;
            D_WRITE = c.d_wr;
            i_pend = c.i_rd; d_pend = c.d_rd | c.d_wr;
            t_i = -1; t_d = -1; strb = 0; rises = 0;
            prev = 1'b0; ovl = 1'b0;
            for (int k = 1; k <= 60; k++) begin
                if (!(i_pend || d_pend)) break;
                @(negedge CLK);
                s = m_rd[0] | m_wr[0];
                if (s) strb++;
                if (s && !prev) rises++;
                prev = s;
                if (m_rd[0] && m_wr[0]) ovl = 1'b1;
                if (i_pend && !i_bw[0]) begin
                    t_i = k; i_pend = 1'b0; I_READ = 1'b0;
                    chk($sformatf("v%0d_irdata", v),
                        i_rdata[0], blk(c.ia));
                end
                if (d_pend && !d_bw[0]) begin
                    t_d = k; d_pend = 1'b0;
                    D_READ = 1'b0; D_WRITE = 1'b0;
                    if (!c.d_wr)
                        chk($sformatf("v%0d_drdata", v),
                            d_rdata[0], blk(c.da));
                end
            end
            chk($sformatf("v%0d_timeout", v),
                128'(i_pend | d_pend), 128'(1'b0));
            if (c.d_first) begin
                chk_i($sformatf("v%0d_td", v), t_d, c.t1);
                if (c.i_rd)
                    chk_i($sformatf("v%0d_ti", v), t_i, c.t2);
            end else begin
                chk_i($sformatf("v%0d_ti", v), t_i, c.t1);
                if (c.d_rd | c.d_wr)
                    chk_i($sformatf("v%0d_td", v), t_d, c.t2);
            end
            chk_i($sformatf("v%0d_strb", v), strb, c.strb);
            chk_i($sformatf("v%0d_rises", v), rises,
                  int'(c.i_rd) + int'(c.d_rd | c.d_wr));
            chk($sformatf("v%0d_ovl", v), 128'(ovl),
                128'(1'b0));
            if (c.d_wr) begin
                chk($sformatf("v%0d_waddr", v),
                    128'(wr_addr[0]), 128'(c.da));
                chk($sformatf("v%0d_wdata", v),
                    wr_data[0], c.wd);
            end
        end

        // I request withdrawn two cycles into its grant
        mem_lat = 5;
        @(negedge CLK);
        I_ADDRESS = 28'h0000040; I_READ = 1'b1;
        strb = 0; last_hi = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (m_rd[0]) begin strb++; last_hi = k; end
            if (k == 2) I_READ = 1'b0;
            if (k == 3)
                chk("wd_ibw", 128'(i_bw[0]), 128'(1'b0));
        end
        chk_i("wd_strb", strb, 6);
        chk_i("wd_lasthi", last_hi, 6);
        I_READ = 1'b1; D_WRITE = 1'b1;
        D_ADDRESS = 28'h0000600; D_WRITEDATA = {4{32'h600D}};
        @(negedge CLK);
        chk("wd_last_d", 128'(m_wr[0]), 128'(1'b1));
        I_READ = 1'b0; D_WRITE = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!(m_rd[0] | m_wr[0])) break;
        end
        @(negedge CLK);

        // Reset during a D write-back, then fresh arbitration
        D_ADDRESS = 28'h0000ABC;
        D_WRITEDATA = {4{32'hDEAD_BEEF}};
        D_WRITE = 1'b1;
        repeat (3) @(negedge CLK);
        chk("mr_strobe", 128'(m_wr[0]), 128'(1'b1));
        RESET = 1'b0;
        @(negedge CLK);
        chk("mr_mwr", 128'(m_wr[0]), 128'(1'b0));
        chk("mr_dbw", 128'(d_bw[0]), 128'(1'b1));
        RESET = 1'b1;
        t6 = -1;
        for (int k = 5; k <= 30; k++) begin
            @(negedge CLK);
            if (!d_bw[0]) begin t6 = k; break; end
        end
        chk_i("mr_done", t6, 11);
        chk("mr_wdata", wr_data[0], {4{32'hDEAD_BEEF}});
        D_WRITE = 1'b0;
        @(negedge CLK);

        // Both held: RR alternates, fixed priority starves I
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        mem_lat = 2;
        I_ADDRESS = 28'h0000070; D_ADDRESS = 28'h0000080;
        I_READ = 1'b1; D_WRITE = 1'b1;
        n0 = 0; n1 = 0; p0 = 1'b0; p1 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (n0 >= 8 && n1 >= 8) break;
            @(negedge CLK);
            if ((m_rd[0] | m_wr[0]) && !p0 && n0 < 8) begin
                gs0[n0] = int'(m_wr[0]); n0++;
            end
            if ((m_rd[1] | m_wr[1]) && !p1 && n1 < 8) begin
                gs1[n1] = int'(m_wr[1]); n1++;
            end
            p0 = m_rd[0] | m_wr[0];
            p1 = m_rd[1] | m_wr[1];
        end
        chk_i("rr_n0", n0, 8);
        chk_i("rr_n1", n1, 8);
        for (int g = 0; g < 8; g++) begin
            if (g < n0)
                chk_i($sformatf("rr_on_g%0d", g), gs0[g],
                      (g % 2 == 0) ? 1 : 0);
            if (g < n1)
                chk_i($sformatf("rr_off_g%0d", g), gs1[g], 1);
        end
        chk("rr_off_istall", 128'(i_bw[1]), 128'(1'b1));
        I_READ = 1'b0; D_WRITE = 1'b0;
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
